// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit scheduler between the CPU byte-store path and the UART core.
// Buffers CPU and trap-report bytes in a FIFO and paces the UART core, which has
// no busy output, by issuing one byte per CLKS_PER_BYTE clocks.
// Optional feature: define UART_TX_SCHED_CRLF_EN to expand each LF (0x0A) into CR LF.
module uart_tx_sched #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int CLKS_PER_BYTE = 8680
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_data,
    input  logic          trap_req,
    input  logic [7:0]    trap_code,
    output logic          uart_wr,
    output logic [7:0]    uart_dat,
    output logic          fifo_full,
    output logic [AW:0]   fifo_count,
    output logic          tx_busy,
    output logic [15:0]   drop_cnt
);

    localparam int            TW           = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BYTE - 1);
    localparam logic [AW:0]   DEPTH_C      = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Saturating increment for the drop counter (holds at 0xFFFF).
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_uart_wr;
    logic            w_uart_wr_nxt;
    logic [7:0]      r_uart_dat;
    logic [7:0]      w_uart_dat_nxt;
    logic [15:0]     r_drop_cnt;

    logic            w_cand_vld;
    logic [7:0]      w_cand_dat;
    logic            w_push;
    logic            w_drop;
    logic            w_issue;
    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_insert_cr;

    // Trap report wins the single enqueue slot; a push while full is lost even
    // if the same edge pops, because acceptance looks at the pre-edge count.
    assign w_cand_vld = trap_req | cpu_we;
    assign w_cand_dat = trap_req ? trap_code : cpu_data;
    assign w_push     = w_cand_vld && (r_count < DEPTH_C);
    assign w_drop     = (trap_req && cpu_we) || (w_cand_vld && (r_count >= DEPTH_C));
    assign w_head     = r_mem[r_rd_ptr];

`ifdef UART_TX_SCHED_CRLF_EN
    logic r_cr_pend;

    // A head LF first emits CR without popping; the next issue sends the LF itself.
    assign w_insert_cr = (w_head == 8'h0A) && !r_cr_pend;

    // Remember that the CR of a CR/LF pair has already gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cr_pend <= 1'b0;
        end else if (w_issue) begin
            r_cr_pend <= w_insert_cr;
        end
    end
`else
    assign w_insert_cr = 1'b0;
`endif

    assign w_pop = w_issue && !w_insert_cr;

    // Next-state, timer and transmit-output decode for the pacing FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_issue        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end else if (r_count != '0) begin
                    w_issue = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_issue) begin
            w_timer_nxt = TIMER_RELOAD;
        end
        w_uart_wr_nxt  = w_issue;
        w_uart_dat_nxt = w_issue ? (w_insert_cr ? 8'h0D : w_head) : r_uart_dat;
    end

    // FSM state, frame timer and registered UART outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_uart_wr  <= 1'b0;
            r_uart_dat <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_uart_wr  <= w_uart_wr_nxt;
            r_uart_dat <= w_uart_dat_nxt;
        end
    end

    // FIFO pointers, occupancy and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cand_dat;
        end
    end

    assign uart_wr    = r_uart_wr;
    assign uart_dat   = r_uart_dat;
    assign fifo_full  = (r_count == DEPTH_C);
    assign fifo_count = r_count;
    assign tx_busy    = (r_state == S_WAIT) || (r_count != '0);
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a queue-based reference model.
// Honours UART_TX_SCHED_CRLF_EN the same way the design does.
module tb_uart_tx_sched;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CPB   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_data = 8'h00;
    logic          trap_req = 1'b0;
    logic [7:0]    trap_code = 8'h00;
    logic          uart_wr;
    logic [7:0]    uart_dat;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          tx_busy;
    logic [15:0]   drop_cnt;

    uart_tx_sched #(.DEPTH(DEPTH), .AW(AW), .CLKS_PER_BYTE(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_data   (cpu_data),
        .trap_req   (trap_req),
        .trap_code  (trap_code),
        .uart_wr    (uart_wr),
        .uart_dat   (uart_dat),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the edge index of the last issue.
    // An issue happens whenever bytes are queued and at least CPB edges have
    // passed since the previous issue; the block is busy for CPB edges after it.
    logic [7:0] mq[$];
    int         m_n    = 0;
    int         m_last = -100000;
    int         m_cnt0;
    int         m_drop = 0;
    bit         m_crp  = 1'b0;
    bit         m_issue, m_pop, m_push, m_drop_ev, m_busy;
    logic       m_wr   = 1'b0;
    logic [7:0] m_dat  = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_last = -100000;
            m_crp  = 1'b0;
            m_drop = 0;
            m_wr   = 1'b0;
            m_dat  = 8'h00;
        end else begin
            m_cnt0  = mq.size();
            m_issue = (m_cnt0 != 0) && (m_n - m_last >= CPB);
            m_pop   = 1'b0;
            m_wr    = m_issue;
            if (m_issue) begin
                m_last = m_n;
`ifdef UART_TX_SCHED_CRLF_EN
                if (mq[0] == 8'h0A && !m_crp) begin
                    m_dat = 8'h0D;
                    m_crp = 1'b1;
                end else begin
                    m_dat = mq[0];
                    m_pop = 1'b1;
                    m_crp = 1'b0;
                end
`else
                m_dat = mq[0];
                m_pop = 1'b1;
`endif
            end
            m_drop_ev = trap_req && cpu_we;
            m_push    = 1'b0;
            if (trap_req || cpu_we) begin
                if (m_cnt0 < DEPTH) m_push = 1'b1;
                else m_drop_ev = 1'b1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(trap_req ? trap_code : cpu_data);
            if (m_drop_ev && m_drop < 65535) m_drop++;
        end
        m_busy = (mq.size() != 0) || (m_n - m_last < CPB);
        m_n++;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("uart_wr",    uart_wr,    m_wr);
            check("uart_dat",   uart_dat,   m_dat);
            check("fifo_count", fifo_count, mq.size());
            check("fifo_full",  fifo_full,  mq.size() == DEPTH);
            check("tx_busy",    tx_busy,    m_busy);
            check("drop_cnt",   drop_cnt,   m_drop);
        end
    end

    // Pulse log for the directed scenarios.
    int         cyc = 0;
    logic [7:0] pd[$];
    int         pc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (uart_wr === 1'b1) begin
            pd.push_back(uart_dat);
            pc.push_back(cyc);
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_we = 1'b0; trap_req = 1'b0;
        tick();
        rst = 1'b0;
        pd.delete();
        pc.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while ((tx_busy !== 1'b0 || uart_wr !== 1'b0) && k < maxc) begin
            tick();
            k++;
        end
        check("drain_timeout", k < maxc, 1);
    endtask

    initial begin
        tick();
        rst = 1'b1;
        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;

        // Single byte after reset.
        do_reset();
        check("rst_count", fifo_count, 0);
        check("rst_wr",    uart_wr,    0);
        check("rst_dat",   uart_dat,   8'h00);
        check("rst_drop",  drop_cnt,   0);
        check("rst_busy",  tx_busy,    0);
        cpu_we = 1'b1; cpu_data = 8'h41; tick();
        cpu_we = 1'b0; tick();
        check("s1_wr",     uart_wr,  1);
        check("s1_dat",    uart_dat, 8'h41);
        tick();
        check("s1_wr_low", uart_wr,  0);
        tick(CPB - 2);
        check("s1_busy_last", tx_busy, 1);
        tick();
        check("s1_idle",   tx_busy,  0);
        check("s1_drop",   drop_cnt, 0);

        // Three back-to-back bytes.
        do_reset();
        cpu_we = 1'b1; cpu_data = 8'h11; tick();
        cpu_data = 8'h22; tick();
        cpu_data = 8'h33; tick();
        cpu_we = 1'b0;
        wait_idle(100);
        check("s2_npulse", pd.size(), 3);
        if (pd.size() == 3) begin
            check("s2_b0", pd[0], 8'h11);
            check("s2_b1", pd[1], 8'h22);
            check("s2_b2", pd[2], 8'h33);
            check("s2_gap0", pc[1] - pc[0], CPB);
            check("s2_gap1", pc[2] - pc[1], CPB);
        end

        // Overfill: sixth write meets a full FIFO on a pop edge and is dropped.
        do_reset();
        cpu_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                check("s3_full",  fifo_full,  1);
                check("s3_cnt4",  fifo_count, 4);
                check("s3_drop0", drop_cnt,   0);
            end
            cpu_data = 8'(i + 1);
            tick();
        end
        cpu_we = 1'b0;
        check("s3_drop1", drop_cnt,   1);
        check("s3_cnt3",  fifo_count, 3);
        wait_idle(200);
        check("s3_npulse", pd.size(), 5);
        if (pd.size() == 5) begin
            for (int i = 0; i < 5; i++) check("s3_order", pd[i], i + 1);
        end

        // Trap and CPU on the same edge.
        do_reset();
        trap_req = 1'b1; trap_code = 8'hE2; cpu_we = 1'b1; cpu_data = 8'h55; tick();
        trap_req = 1'b0; cpu_we = 1'b0;
        wait_idle(100);
        check("s4_npulse", pd.size(), 1);
        if (pd.size() == 1) check("s4_byte", pd[0], 8'hE2);
        check("s4_drop", drop_cnt, 1);

        // Reset in the middle of a frame.
        do_reset();
        cpu_we = 1'b1; cpu_data = 8'hA1; tick();
        cpu_data = 8'hA2; tick();
        cpu_data = 8'hA3; tick();
        cpu_we = 1'b0; tick(2);
        check("s5_busy_pre", tx_busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s5_count", fifo_count, 0);
        check("s5_wr",    uart_wr,    0);
        check("s5_dat",   uart_dat,   8'h00);
        pd.delete(); pc.delete();
        tick(3 * CPB);
        check("s5_silent", pd.size(), 0);
        cpu_we = 1'b1; cpu_data = 8'h41; tick();
        cpu_we = 1'b0; tick();
        check("s5_wr_again",  uart_wr,  1);
        check("s5_dat_again", uart_dat, 8'h41);
        wait_idle(100);

        // Line feed handling.
        do_reset();
        cpu_we = 1'b1; cpu_data = 8'h0A; tick();
        cpu_we = 1'b0;
        wait_idle(100);
`ifdef UART_TX_SCHED_CRLF_EN
        check("s6_npulse", pd.size(), 2);
        if (pd.size() == 2) begin
            check("s6_cr",  pd[0], 8'h0D);
            check("s6_lf",  pd[1], 8'h0A);
            check("s6_gap", pc[1] - pc[0], CPB);
        end
`else
        check("s6_npulse", pd.size(), 1);
        if (pd.size() == 1) check("s6_lf", pd[0], 8'h0A);
`endif

        // Randomized traffic, alternating quiet and bursty phases.
        for (int blk = 0; blk < 8; blk++) begin
            int pct;
            pct = (blk % 2 == 1) ? 80 : 12;
            for (int c = 0; c < 250; c++) begin
                rst       = ($urandom_range(0, 299) == 0);
                cpu_we    = ($urandom_range(0, 99) < pct);
                trap_req  = ($urandom_range(0, 99) < pct / 4);
                cpu_data  = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                trap_code = 8'($urandom_range(0, 255));
                tick();
            end
        end
        rst = 1'b0; cpu_we = 1'b0; trap_req = 1'b0;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
